mux_scan_ctrl: RTL
==================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter: SETTLE, default 1, cycles S is held stable before O is sampled (legal 1..15).
REQ-002 CLK  input  1  rising-edge clock, sole clock.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 START  input  1  scan request, sampled in IDLE only.
REQ-005 MASK  input  8  channel enables, bit n = channel n, latched on accepted START.
REQ-006 O  input  4  data returned by the downstream 8:1 4-bit mux for the current S.
REQ-007 S  output  3  select driven to the mux.
REQ-008 BUSY  output  1  high from accepted START until DONE is asserted.
REQ-009 VALID  output  1  one-cycle pulse per captured channel.
REQ-010 CH  output  3  channel index of DATA.
REQ-011 DATA  output  4  captured mux output.
REQ-012 DONE  output  1  one-cycle pulse at scan end.
REQ-013 MAX  output  4  largest DATA of the current or last scan.
REQ-014 MAX_CH  output  3  channel of MAX.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, CAPT, FIN; all outputs are registered.
REQ-016 In IDLE with START=1 and MASK!=0: latch MASK, clear MAX/MAX_CH to 0, set S to the lowest enabled channel, set BUSY, load the settle counter with SETTLE, go to WAIT.
REQ-017 In IDLE with START=1 and MASK==0: go to FIN without VALID; MAX/MAX_CH clear to 0.
REQ-018 WAIT SHALL last exactly SETTLE cycles, so O is sampled SETTLE edges after the edge that changed S.
REQ-019 On the capture edge: DATA<=O, CH<=S, and VALID pulses high for one cycle.
REQ-020 On the capture edge, if O>MAX (unsigned, strict), MAX<=O and MAX_CH<=S; ties keep the earlier (lower) channel.
REQ-021 On the capture edge, if a higher enabled channel exists, S SHALL move to the next enabled channel and WAIT SHALL restart; otherwise the FSM goes to FIN and S holds.
REQ-022 FIN SHALL assert DONE for one cycle, clear BUSY in the same cycle, and return to IDLE.
REQ-023 START while not in IDLE SHALL be ignored; MASK changes mid-scan SHALL have no effect.
REQ-024 DATA, CH, MAX, MAX_CH SHALL hold their values between scans.
REQ-025 With SETTLE=1 and MASK=8'hFF, VALID SHALL pulse on 8 consecutive cycles, and DONE SHALL pulse on the cycle after the last VALID.

Reset
REQ-026 With RST_N low, at any time including mid-scan, the block SHALL immediately force IDLE and S=0, BUSY=0, VALID=0, DONE=0, CH=0, DATA=0, MAX=0, MAX_CH=0, latched mask=0, counter=0.
REQ-027 After RST_N rises, the first START SHALL be accepted on the first rising CLK edge.

Structure
REQ-028 The FSM state encodings, channel count (8), and data width (4) SHALL live in a shared package or include file used by the mux and this block.
REQ-029 One sub-module, next_chan_enc, SHALL compute the next enabled channel above a given index from the mask, plus a none-left flag; the rest is flat.

Verification (bench models the mux combinationally, channel n = 4'h8+n)
REQ-030 Hold RST_N low, then release: all outputs 0; pull RST_N low mid-scan: outputs 0 immediately and the FSM is in IDLE.
REQ-031 SETTLE=1, MASK=8'hFF, 1-cycle START: VALID on 8 consecutive cycles, CH 0..7 with DATA 8..F, then DONE; MAX=F, MAX_CH=7.
REQ-032 MASK=8'b1010_0100: exactly 3 VALIDs, (CH,DATA) = (2,A), (5,D), (7,F); DONE follows; BUSY is low after DONE.
REQ-033 MASK=8'h00: DONE one cycle after START, no VALID, MAX=0.
REQ-034 SETTLE=3, all mux inputs 4'h5, MASK=8'h18: VALID spacing 3 cycles; MAX=5, MAX_CH=3 (tie rule).
REQ-035 START re-pulsed and MASK changed mid-scan: the scan is unaffected, and only one DONE occurs.

Source files
------------

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan controller and the 8:1 4-bit mux it drives.
//   NUM_CH / CH_W  : channel count and select width
//   DATA_W         : mux data width
//   CNT_W          : settle counter width (SETTLE legal range 1..15)
//   state_t        : scan FSM state encoding
//   lowest_chan()  : index of the lowest set bit of a channel mask
package mux_scan_ctrl_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned CNT_W  = 4;

  typedef logic [CH_W-1:0]   chan_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [NUM_CH-1:0] mask_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CAPT = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Lowest enabled channel; returns 0 for an empty mask.
  function automatic chan_t lowest_chan(input mask_t m);
    chan_t r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) r = CH_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/next_chan_enc.sv
// Next enabled channel strictly above cur in mask.
//   mask  : channel enables
//   cur   : current channel index
//   nxt_c : lowest enabled channel above cur (0 when none)
//   none_c: no enabled channel above cur
module next_chan_enc
  import mux_scan_ctrl_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  output logic [CH_W-1:0]   nxt_c,
  output logic              none_c
);

  // Scan downward so the lowest qualifying channel is the last one written.
  always_comb begin
    nxt_c  = '0;
    none_c = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        nxt_c  = CH_W'(i);
        none_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled channels of an external 8:1 4-bit mux, holding each select
// stable for SETTLE cycles before sampling, and tracks the maximum value seen.
//   clk, rst_n   : clock, async active-low reset
//   start        : scan request (IDLE only)
//   mask         : channel enables, latched on accepted start
//   o            : mux output for the current select
//   s            : mux select
//   busy         : scan in progress
//   valid        : one-cycle pulse per captured channel (ch, data)
//   done         : one-cycle pulse at scan end
//   max, max_ch  : largest captured value of current/last scan and its channel
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] mask,
  input  logic [DATA_W-1:0] o,
  output logic [CH_W-1:0]   s,
  output logic              busy,
  output logic              valid,
  output logic [CH_W-1:0]   ch,
  output logic [DATA_W-1:0] data,
  output logic              done,
  output logic [DATA_W-1:0] max,
  output logic [CH_W-1:0]   max_ch
);

  // The settle window spans WAIT plus the CAPT cycle; with SETTLE=1 the
  // FSM goes straight to CAPT so captures can land on consecutive cycles.
  localparam state_t SETTLE_ST = (SETTLE == 1) ? ST_CAPT : ST_WAIT;

  state_t            state;
  logic [NUM_CH-1:0] mask_q;
  logic [CNT_W-1:0]  cnt;
  logic [CH_W-1:0]   nxt_c;
  logic              none_c;

  next_chan_enc u_next_chan_enc (
    .mask   (mask_q),
    .cur    (s),
    .nxt_c  (nxt_c),
    .none_c (none_c)
  );

  // Scan FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mask_q <= '0;
      cnt    <= '0;
      s      <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      ch     <= '0;
      data   <= '0;
      done   <= 1'b0;
      max    <= '0;
      max_ch <= '0;
    end else begin
      valid <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mask_q <= mask;
            max    <= '0;
            max_ch <= '0;
            busy   <= 1'b1;
            if (mask != '0) begin
              s     <= lowest_chan(mask);
              cnt   <= CNT_W'(SETTLE);
              state <= SETTLE_ST;
            end else begin
              state <= ST_FIN;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(2)) state <= ST_CAPT;
        end
        ST_CAPT: begin
          valid <= 1'b1;
          data  <= o;
          ch    <= s;
          // Strict compare keeps the lower channel on ties.
          if (o > max) begin
            max    <= o;
            max_ch <= s;
          end
          if (!none_c) begin
            s     <= nxt_c;
            cnt   <= CNT_W'(SETTLE);
            state <= SETTLE_ST;
          end else begin
            cnt   <= '0;
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
